// File: rtl/bbc_keyboard.sv
// BBC Micro keyboard emulation: PS/2 receiver, scan-code decoder, 10x8 key
// matrix with option links, autoscan column counter and VIA-facing outputs.
module bbc_keyboard #(
    parameter logic [15:0] TIMEOUT = 16'd50000,
    parameter logic [7:0]  LINKS   = 8'h00
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic       clk_en,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    input  logic       nKBEN,
    input  logic [3:0] COLUMN_SEL,
    input  logic [2:0] ROW_SEL,
    output logic       KEY_PRESSED,
    output logic       CA2,
    output logic       nBREAK
);

    localparam int unsigned NUM_COLS = 10;
    localparam int unsigned NUM_ROWS = 8;
    localparam int unsigned COL_W    = 4;
    localparam int unsigned ROW_W    = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // PS/2 line synchronisers and edge detection
    logic [1:0]          clk_sync_q;
    logic [1:0]          data_sync_q;
    logic                clk_prev_q;
    logic                ps2_fall_c;
    logic                ps2_bit_c;

    // receiver
    rx_state_t           state_q;
    rx_state_t           state_d;
    logic [7:0]          shift_q;
    logic [2:0]          bit_cnt_q;
    logic                parity_q;
    logic [15:0]         to_cnt_q;
    logic                timeout_c;
    logic                start_c;
    logic                shift_en_c;
    logic                parity_en_c;
    logic                frame_ok_c;
    logic                byte_valid_q;
    logic [7:0]          byte_q;

    // decoder and matrix
    logic                ext_q;
    logic                rel_q;
    logic [NUM_COLS-1:0][NUM_ROWS-1:0] key_q;
    logic                nbreak_q;
    logic [7:0]          map_c;
    logic                map_hit_c;
    logic [COL_W-1:0]    map_col_c;
    logic [ROW_W-1:0]    map_row_c;

    // scan
    logic [COL_W-1:0]    scan_col_q;
    logic [COL_W-1:0]    active_col_c;
    logic [15:0][NUM_ROWS-1:0] eff_c;
    logic                ca2_q;

    // PS/2 scan code (set 2) to BBC matrix position: {hit, col[3:0], row[2:0]}
    function automatic logic [7:0] key_map(input logic ext, input logic [7:0] code);
        logic [7:0] m;
        m = 8'h00;
        case ({ext, code})
            // column 0
            9'h012, 9'h059: m = {1'b1, 4'd0, 3'd0}; // Shift
            9'h015:         m = {1'b1, 4'd0, 3'd1}; // Q
            9'h009:         m = {1'b1, 4'd0, 3'd2}; // f0 (F10)
            9'h016:         m = {1'b1, 4'd0, 3'd3}; // 1
            9'h058:         m = {1'b1, 4'd0, 3'd4}; // Caps Lock
            9'h011:         m = {1'b1, 4'd0, 3'd5}; // Shift Lock (Alt)
            9'h00D:         m = {1'b1, 4'd0, 3'd6}; // Tab
            9'h076:         m = {1'b1, 4'd0, 3'd7}; // Escape
            // column 1
            9'h014, 9'h114: m = {1'b1, 4'd1, 3'd0}; // Ctrl
            9'h026:         m = {1'b1, 4'd1, 3'd1}; // 3
            9'h01D:         m = {1'b1, 4'd1, 3'd2}; // W
            9'h01E:         m = {1'b1, 4'd1, 3'd3}; // 2
            9'h01C:         m = {1'b1, 4'd1, 3'd4}; // A
            9'h01B:         m = {1'b1, 4'd1, 3'd5}; // S
            9'h01A:         m = {1'b1, 4'd1, 3'd6}; // Z
            9'h005:         m = {1'b1, 4'd1, 3'd7}; // f1
            // column 2
            9'h025:         m = {1'b1, 4'd2, 3'd1}; // 4
            9'h024:         m = {1'b1, 4'd2, 3'd2}; // E
            9'h023:         m = {1'b1, 4'd2, 3'd3}; // D
            9'h022:         m = {1'b1, 4'd2, 3'd4}; // X
            9'h021:         m = {1'b1, 4'd2, 3'd5}; // C
            9'h029:         m = {1'b1, 4'd2, 3'd6}; // Space
            9'h006:         m = {1'b1, 4'd2, 3'd7}; // f2
            // column 3
            9'h02E:         m = {1'b1, 4'd3, 3'd1}; // 5
            9'h02C:         m = {1'b1, 4'd3, 3'd2}; // T
            9'h02D:         m = {1'b1, 4'd3, 3'd3}; // R
            9'h02B:         m = {1'b1, 4'd3, 3'd4}; // F
            9'h034:         m = {1'b1, 4'd3, 3'd5}; // G
            9'h02A:         m = {1'b1, 4'd3, 3'd6}; // V
            9'h004:         m = {1'b1, 4'd3, 3'd7}; // f3
            // column 4
            9'h00C:         m = {1'b1, 4'd4, 3'd1}; // f4
            9'h03D:         m = {1'b1, 4'd4, 3'd2}; // 7
            9'h036:         m = {1'b1, 4'd4, 3'd3}; // 6
            9'h035:         m = {1'b1, 4'd4, 3'd4}; // Y
            9'h033:         m = {1'b1, 4'd4, 3'd5}; // H
            9'h032:         m = {1'b1, 4'd4, 3'd6}; // B
            9'h003:         m = {1'b1, 4'd4, 3'd7}; // f5
            // column 5
            9'h03E:         m = {1'b1, 4'd5, 3'd1}; // 8
            9'h043:         m = {1'b1, 4'd5, 3'd2}; // I
            9'h03C:         m = {1'b1, 4'd5, 3'd3}; // U
            9'h03B:         m = {1'b1, 4'd5, 3'd4}; // J
            9'h031:         m = {1'b1, 4'd5, 3'd5}; // N
            9'h03A:         m = {1'b1, 4'd5, 3'd6}; // M
            9'h00B:         m = {1'b1, 4'd5, 3'd7}; // f6
            // column 6
            9'h083:         m = {1'b1, 4'd6, 3'd1}; // f7
            9'h046:         m = {1'b1, 4'd6, 3'd2}; // 9
            9'h044:         m = {1'b1, 4'd6, 3'd3}; // O
            9'h042:         m = {1'b1, 4'd6, 3'd4}; // K
            9'h04B:         m = {1'b1, 4'd6, 3'd5}; // L
            9'h041:         m = {1'b1, 4'd6, 3'd6}; // ,
            9'h00A:         m = {1'b1, 4'd6, 3'd7}; // f8
            // column 7
            9'h04E:         m = {1'b1, 4'd7, 3'd1}; // -
            9'h045:         m = {1'b1, 4'd7, 3'd2}; // 0
            9'h04D:         m = {1'b1, 4'd7, 3'd3}; // P
            9'h052:         m = {1'b1, 4'd7, 3'd4}; // @ (')
            9'h04C:         m = {1'b1, 4'd7, 3'd5}; // ;
            9'h049:         m = {1'b1, 4'd7, 3'd6}; // .
            9'h001:         m = {1'b1, 4'd7, 3'd7}; // f9
            // column 8
            9'h055:         m = {1'b1, 4'd8, 3'd1}; // ^ (=)
            9'h00E:         m = {1'b1, 4'd8, 3'd2}; // _ (`)
            9'h054:         m = {1'b1, 4'd8, 3'd3}; // [
            9'h05D:         m = {1'b1, 4'd8, 3'd4}; // : (#)
            9'h05B:         m = {1'b1, 4'd8, 3'd5}; // ]
            9'h04A:         m = {1'b1, 4'd8, 3'd6}; // /
            9'h061:         m = {1'b1, 4'd8, 3'd7}; // backslash
            // column 9
            9'h16B:         m = {1'b1, 4'd9, 3'd1}; // cursor left
            9'h172:         m = {1'b1, 4'd9, 3'd2}; // cursor down
            9'h175:         m = {1'b1, 4'd9, 3'd3}; // cursor up
            9'h05A:         m = {1'b1, 4'd9, 3'd4}; // Return
            9'h066, 9'h171: m = {1'b1, 4'd9, 3'd5}; // Delete
            9'h169:         m = {1'b1, 4'd9, 3'd6}; // Copy (End)
            9'h174:         m = {1'b1, 4'd9, 3'd7}; // cursor right
            default:        m = 8'h00;
        endcase
        return m;
    endfunction

    // two-flop synchronisers (idle-high) plus previous clock level
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
            data_sync_q <= {data_sync_q[0], PS2_DATA};
            clk_prev_q  <= clk_sync_q[1];
        end
    end

    assign ps2_fall_c = clk_prev_q & ~clk_sync_q[1];
    assign ps2_bit_c  = data_sync_q[1];
    assign timeout_c  = (state_q != IDLE) && !ps2_fall_c && (to_cnt_q >= (TIMEOUT - 16'd1));

    // receiver state register
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // receiver next-state logic
    always_comb begin
        state_d = state_q;
        if (timeout_c) begin
            state_d = IDLE;
        end else if (ps2_fall_c) begin
            case (state_q)
                IDLE:    if (!ps2_bit_c) state_d = DATA;
                DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // receiver datapath strobes
    always_comb begin
        start_c     = 1'b0;
        shift_en_c  = 1'b0;
        parity_en_c = 1'b0;
        frame_ok_c  = 1'b0;
        if (ps2_fall_c) begin
            case (state_q)
                IDLE:    start_c     = !ps2_bit_c;
                DATA:    shift_en_c  = 1'b1;
                PARITY:  parity_en_c = 1'b1;
                STOP:    frame_ok_c  = ps2_bit_c && (^{shift_q, parity_q});
                default: ;
            endcase
        end
    end

    // shift register, bit count, inactivity counter and byte strobe
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            parity_q     <= 1'b0;
            to_cnt_q     <= 16'd0;
            byte_valid_q <= 1'b0;
            byte_q       <= 8'h00;
        end else begin
            if (timeout_c || start_c) begin
                shift_q   <= 8'h00;
                bit_cnt_q <= 3'd0;
                parity_q  <= 1'b0;
            end else begin
                if (shift_en_c) begin
                    shift_q   <= {ps2_bit_c, shift_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                if (parity_en_c) begin
                    parity_q <= ps2_bit_c;
                end
            end
            if ((state_q == IDLE) || ps2_fall_c || timeout_c) begin
                to_cnt_q <= 16'd0;
            end else begin
                to_cnt_q <= to_cnt_q + 16'd1;
            end
            byte_valid_q <= frame_ok_c;
            if (frame_ok_c) begin
                byte_q <= shift_q;
            end
        end
    end

    assign map_c     = key_map(ext_q, byte_q);
    assign map_hit_c = map_c[7];
    assign map_col_c = map_c[6:3];
    assign map_row_c = map_c[2:0];

    // scan-code decoder: prefix flags, matrix updates and Break
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            ext_q    <= 1'b0;
            rel_q    <= 1'b0;
            key_q    <= '0;
            nbreak_q <= 1'b1;
        end else if (byte_valid_q) begin
            if (byte_q == 8'hE0) begin
                ext_q <= 1'b1;
            end else if (byte_q == 8'hF0) begin
                rel_q <= 1'b1;
            end else if (byte_q == 8'hAA) begin
                ext_q <= ext_q;
            end else if ((byte_q == 8'h00) || (byte_q == 8'hFF)) begin
                key_q <= '0;
            end else begin
                if (byte_q == 8'h07) begin
                    nbreak_q <= rel_q;
                end else if (map_hit_c) begin
                    key_q[map_col_c][map_row_c] <= ~rel_q;
                end
                ext_q <= 1'b0;
                rel_q <= 1'b0;
            end
        end
    end

    // visible matrix: option links overlay row 0 of columns 2..9, columns 10..15 read zero
    always_comb begin
        eff_c = '0;
        for (int unsigned c = 0; c < NUM_COLS; c++) begin
            eff_c[c] = key_q[c];
        end
        for (int unsigned c = 2; c < NUM_COLS; c++) begin
            eff_c[c][0] = LINKS[c - 2];
        end
    end

    // autoscan column counter, wraps after column 9
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            scan_col_q <= '0;
        end else if (clk_en && nKBEN) begin
            if (scan_col_q == COL_W'(NUM_COLS - 1)) begin
                scan_col_q <= '0;
            end else begin
                scan_col_q <= scan_col_q + COL_W'(1);
            end
        end
    end

    assign active_col_c = nKBEN ? scan_col_q : COLUMN_SEL;

    // column-active interrupt: any key in rows 1..7 of the active column
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            ca2_q <= 1'b0;
        end else begin
            ca2_q <= |eff_c[active_col_c][NUM_ROWS-1:1];
        end
    end

    assign KEY_PRESSED = eff_c[COLUMN_SEL][ROW_SEL];
    assign CA2         = ca2_q;
    assign nBREAK      = nbreak_q;

endmodule

// File: tb/tb_bbc_keyboard.sv
// Testbench for bbc_keyboard: table of PS/2 byte sequences with expected key
// and CA2 state, plus hand sequences for framing errors, timeout, Break,
// autoscan and mid-frame reset.
module tb_bbc_keyboard;

    localparam logic [15:0] TOUT = 16'd300;

    logic       clk = 1'b0;
    logic       nRESET = 1'b0;
    logic       clk_en = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic       nKBEN = 1'b0;
    logic [3:0] COLUMN_SEL = 4'd0;
    logic [2:0] ROW_SEL = 3'd0;
    logic       KEY_PRESSED;
    logic       CA2;
    logic       nBREAK;

    int checks = 0;
    int errors = 0;

    bbc_keyboard #(.TIMEOUT(TOUT), .LINKS(8'h81)) dut (
        .clk         (clk),
        .nRESET      (nRESET),
        .clk_en      (clk_en),
        .PS2_CLK     (PS2_CLK),
        .PS2_DATA    (PS2_DATA),
        .nKBEN       (nKBEN),
        .COLUMN_SEL  (COLUMN_SEL),
        .ROW_SEL     (ROW_SEL),
        .KEY_PRESSED (KEY_PRESSED),
        .CA2         (CA2),
        .nBREAK      (nBREAK)
    );

    always #5 clk = ~clk;

    // scan tick: one clk wide every 8 clks, driven away from the active edge
    int div = 0;
    always @(negedge clk) begin
        div = (div == 7) ? 0 : div + 1;
        clk_en = (div == 0);
    end

    // reference scan model: column counter and registered CA2 for a known key set
    logic [15:0] scan_cols = 16'h0000;
    logic [3:0]  m_cnt;
    logic        m_ca2;
    logic [3:0]  m_act;
    assign m_act = nKBEN ? m_cnt : COLUMN_SEL;

    always @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            m_cnt <= 4'd0;
            m_ca2 <= 1'b0;
        end else begin
            m_ca2 <= scan_cols[m_act];
            if (clk_en && nKBEN) m_cnt <= (m_cnt == 4'd9) ? 4'd0 : m_cnt + 4'd1;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          n;
        logic [31:0] bytes;
        logic [3:0]  col;
        logic [2:0]  row;
        logic        kp;
        logic        ca2;
    } vec_t;

    vec_t vt[23];
    vec_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        PS2_DATA = b;
        repeat (10) @(negedge clk);
        PS2_CLK = 1'b0;
        repeat (20) @(negedge clk);
        PS2_CLK = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(1'b1);
        PS2_DATA = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic check_key(input string name, input logic [3:0] c, input logic [2:0] r, input logic exp);
        COLUMN_SEL = c;
        ROW_SEL = r;
        repeat (3) @(negedge clk);
        check(name, 32'(KEY_PRESSED), 32'(exp));
    endtask

    task automatic run_scan(input string name, input int n, input int exp_hi);
        int bad;
        int hi;
        bad = 0;
        hi = 0;
        repeat (n) begin
            @(negedge clk);
            if (CA2 !== m_ca2) bad++;
            if (CA2 === 1'b1) hi++;
        end
        check({name, "_phase_mismatches"}, 32'(bad), 32'd0);
        check({name, "_high_cycles"}, 32'(hi), 32'(exp_hi));
    endtask

    initial begin
        vec_t e;

        // {count, bytes (first byte in [7:0]), col, row, KEY_PRESSED, CA2}
        vt[0]  = '{1, 32'h0000001C, 4'd1,  3'd4, 1'b1, 1'b1}; // A press
        vt[1]  = '{2, 32'h00001CF0, 4'd1,  3'd4, 1'b0, 1'b0}; // A release
        vt[2]  = '{1, 32'h00000012, 4'd0,  3'd0, 1'b1, 1'b0}; // Shift only: row 0 excluded from CA2
        vt[3]  = '{1, 32'h00000076, 4'd0,  3'd7, 1'b1, 1'b1}; // Escape
        vt[4]  = '{2, 32'h000076F0, 4'd0,  3'd7, 1'b0, 1'b0}; // Escape release
        vt[5]  = '{2, 32'h000012F0, 4'd0,  3'd0, 1'b0, 1'b0}; // Shift release
        vt[6]  = '{1, 32'h0000005A, 4'd9,  3'd4, 1'b1, 1'b1}; // Return
        vt[7]  = '{3, 32'h005AF0E0, 4'd9,  3'd4, 1'b1, 1'b1}; // E0 5A is not Return
        vt[8]  = '{2, 32'h00005AF0, 4'd9,  3'd4, 1'b0, 1'b0}; // Return release
        vt[9]  = '{2, 32'h00006BE0, 4'd9,  3'd1, 1'b1, 1'b1}; // cursor left
        vt[10] = '{1, 32'h0000006B, 4'd9,  3'd1, 1'b1, 1'b1}; // keypad 4: unmapped
        vt[11] = '{3, 32'h006BF0E0, 4'd9,  3'd1, 1'b0, 1'b0}; // cursor left release
        vt[12] = '{2, 32'h000029F0, 4'd2,  3'd6, 1'b0, 1'b0}; // release of unpressed Space
        vt[13] = '{1, 32'h00000029, 4'd2,  3'd6, 1'b1, 1'b1}; // Space
        vt[14] = '{1, 32'h00000029, 4'd2,  3'd6, 1'b1, 1'b1}; // repeated make
        vt[15] = '{1, 32'h000000AA, 4'd2,  3'd0, 1'b1, 1'b1}; // AA ignored; link c2r0
        vt[16] = '{3, 32'h001CF01C, 4'd1,  3'd4, 1'b0, 1'b0}; // press+release back to back
        vt[17] = '{1, 32'h0000001C, 4'd12, 3'd4, 1'b0, 1'b0}; // column 12 reads zero
        vt[18] = '{1, 32'h00000000, 4'd1,  3'd4, 1'b0, 1'b0}; // 00 clears matrix
        vt[19] = '{0, 32'h00000000, 4'd9,  3'd0, 1'b1, 1'b0}; // link c9r0 survives clear
        vt[20] = '{0, 32'h00000000, 4'd2,  3'd6, 1'b0, 1'b0}; // Space cleared
        vt[21] = '{1, 32'h00000014, 4'd1,  3'd0, 1'b1, 1'b0}; // Ctrl
        vt[22] = '{3, 32'h0014F0E0, 4'd1,  3'd0, 1'b0, 1'b0}; // right Ctrl release

        // reset state
        repeat (5) @(negedge clk);
        check("reset_nbreak", 32'(nBREAK), 32'd1);
        check("reset_ca2", 32'(CA2), 32'd0);
        nRESET = 1'b1;
        repeat (5) @(negedge clk);
        check_key("reset_link_c2r0", 4'd2, 3'd0, 1'b1);
        check_key("reset_shift_c0r0", 4'd0, 3'd0, 1'b0);

        // table-driven manual-scan vectors
        for (int i = 0; i < 23; i++) begin
            for (int k = 0; k < vt[i].n; k++) send_frame(8'(vt[i].bytes >> (8 * k)), 1'b0);
            exp_q.push_back(vt[i]);
            COLUMN_SEL = vt[i].col;
            ROW_SEL = vt[i].row;
            repeat (3) @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("vec%0d_key", i), 32'(KEY_PRESSED), 32'(e.kp));
            check($sformatf("vec%0d_ca2", i), 32'(CA2), 32'(e.ca2));
        end

        // bad parity, then a frame stalled past the timeout, then a good frame
        send_frame(8'h1C, 1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        repeat (int'(TOUT) + 50) @(negedge clk);
        send_frame(8'h5A, 1'b0);
        check_key("badpar_a_clear", 4'd1, 3'd4, 1'b0);
        check_key("after_timeout_return", 4'd9, 3'd4, 1'b1);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h5A, 1'b0);

        // Break key
        send_frame(8'h07, 1'b0);
        repeat (3) @(negedge clk);
        check("break_press", 32'(nBREAK), 32'd0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h07, 1'b0);
        repeat (3) @(negedge clk);
        check("break_release", 32'(nBREAK), 32'd1);

        // autoscan with Space held: CA2 only while column 2 is scanned
        send_frame(8'h29, 1'b0);
        scan_cols = 16'h0004;
        nKBEN = 1'b1;
        repeat (100) @(negedge clk);
        run_scan("scan_space", 800, 80);
        nKBEN = 1'b0;
        repeat (37) @(negedge clk);

        // mid-frame reset with Break and A held
        send_frame(8'hF0, 1'b0);
        send_frame(8'h29, 1'b0);
        send_frame(8'h07, 1'b0);
        send_frame(8'h1C, 1'b0);
        repeat (3) @(negedge clk);
        check("break_before_reset", 32'(nBREAK), 32'd0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        PS2_CLK = 1'b0;
        repeat (5) @(negedge clk);
        nRESET = 1'b0;
        repeat (10) @(negedge clk);
        PS2_CLK = 1'b1;
        PS2_DATA = 1'b1;
        scan_cols = 16'h0000;
        repeat (5) @(negedge clk);
        nRESET = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_nbreak", 32'(nBREAK), 32'd1);
        check_key("rst_a_cleared", 4'd1, 3'd4, 1'b0);
        check("rst_ca2_col1", 32'(CA2), 32'd0);
        check_key("rst_link_c2r0", 4'd2, 3'd0, 1'b1);
        check_key("rst_link_c9r0", 4'd9, 3'd0, 1'b1);

        // receiver works after reset; autoscan restarts from column 0
        send_frame(8'h1C, 1'b0);
        check_key("post_rst_a", 4'd1, 3'd4, 1'b1);
        scan_cols = 16'h0002;
        nKBEN = 1'b1;
        repeat (100) @(negedge clk);
        run_scan("scan_after_reset", 800, 80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
